issue_bypass: RTL and testbench

- Issue stage between decode and the integer/memory execution units.
- Holds one decoded instruction and reads its source operands from the register file.
- Tracks in-flight destination writes in a per-register scoreboard and forwards results from the completion buses.
- Releases the instruction to execute only when every operand is valid; stalls otherwise.

---
 rtl/core_pkg.sv | 54 +++++
 rtl/issue_bypass_scoreboard.sv | 60 ++++++
 rtl/issue_bypass.sv | 160 ++++++++++++++++
 tb/tb_issue_bypass.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core types: XLEN, register-file geometry and the decoded instruction
// record carried through the issue stage.
`ifndef XLEN
`define XLEN 32
`endif

package core_pkg;

  localparam int XLEN            = `XLEN;
  localparam int NUM_REGS        = 32;
  localparam int REG_W           = 5;
  localparam int ISSUE_PAYLOAD_W = 32;

  typedef struct packed {
    logic [XLEN-1:0]            pc;
    logic [REG_W-1:0]           rs1;
    logic [REG_W-1:0]           rs2;
    logic [REG_W-1:0]           rd;
    logic                       uses_rs1;
    logic                       uses_rs2;
    logic                       writes_rd;
    logic [ISSUE_PAYLOAD_W-1:0] payload;
  } issue_instr_t;

  typedef struct packed {
    logic            ready;
    logic [XLEN-1:0] value;
  } src_res_t;

  // A pending register is only readable through a same-cycle bus hit.
  function automatic src_res_t resolve_src(
    input logic             uses,
    input logic [REG_W-1:0] idx,
    input logic             pend,
    input logic             hit,
    input logic [XLEN-1:0]  byp,
    input logic [XLEN-1:0]  rf
  );
    src_res_t r;
    r.ready = 1'b1;
    r.value = '0;
    if (uses && (idx != '0)) begin
      if (!pend) begin
        r.value = rf;
      end else if (hit) begin
        r.value = byp;
      end else begin
        r.ready = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/issue_bypass_scoreboard.sv
// Per-register pending-write vector: cleared by completion buses, set on issue
// (set wins on a collision); x0 is never pending.
module issue_bypass_scoreboard
  import core_pkg::*;
#(
  parameter int NUM_CLR = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     set_en,
  input  logic [REG_W-1:0]         set_idx,
  input  logic [NUM_CLR-1:0]       clr_valid,
  input  logic [NUM_CLR*REG_W-1:0] clr_idx,
  input  logic [REG_W-1:0]         rs1_idx,
  input  logic [REG_W-1:0]         rs2_idx,
  input  logic [REG_W-1:0]         rd_idx,
  output logic [NUM_REGS-1:0]      pending,
  output logic                     rs1_pend,
  output logic                     rs2_pend,
  output logic                     rd_pend
);

  logic [NUM_REGS-1:0] pending_reg;
  logic [NUM_REGS-1:0] pending_next;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] set_mask;

  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < NUM_CLR; i++) begin
      if (clr_valid[i]) clr_mask[clr_idx[i*REG_W +: REG_W]] = 1'b1;
    end
    set_mask = '0;
    if (set_en) set_mask[set_idx] = 1'b1;
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bit
      if (gi == 0) begin : g_zero
        assign pending_next[gi] = 1'b0;
      end else begin : g_live
        assign pending_next[gi] = set_mask[gi] | (pending_reg[gi] & ~clr_mask[gi]);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  assign pending  = pending_reg;
  assign rs1_pend = pending_reg[rs1_idx];
  assign rs2_pend = pending_reg[rs2_idx];
  assign rd_pend  = pending_reg[rd_idx];

endmodule

// File: rtl/issue_bypass.sv
// Single-entry issue slot: reads operands from the register file, bypasses
// completion buses onto pending sources and stalls on RAW/WAW hazards.
module issue_bypass
  import core_pkg::*;
#(
  parameter int NUM_RES   = 2,
  parameter int PAYLOAD_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [4:0]               in_rd,
  input  logic                     in_uses_rs1,
  input  logic                     in_uses_rs2,
  input  logic                     in_writes_rd,
  input  logic [PAYLOAD_W-1:0]     in_payload,
  output logic [4:0]               rf_rs1_sel,
  output logic [4:0]               rf_rs2_sel,
  input  logic [XLEN-1:0]          rf_rs1_data,
  input  logic [XLEN-1:0]          rf_rs2_data,
  input  logic [NUM_RES-1:0]       res_valid,
  input  logic [NUM_RES*5-1:0]     res_rd,
  input  logic [NUM_RES*XLEN-1:0]  res_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_op1,
  output logic [XLEN-1:0]          out_op2,
  output logic [4:0]               out_rd,
  output logic                     out_writes_rd,
  output logic [PAYLOAD_W-1:0]     out_payload
);

  generate
    if (PAYLOAD_W != ISSUE_PAYLOAD_W) begin : g_bad_payload
      $error("issue_bypass: PAYLOAD_W must match core_pkg::ISSUE_PAYLOAD_W");
    end
  endgenerate

  issue_instr_t slot_reg;
  issue_instr_t in_instr;
  logic         slot_valid_reg;

  logic [NUM_REGS-1:0] pending_vec;
  logic                rs1_pend;
  logic                rs2_pend;
  logic                rd_pend;

  logic [NUM_RES-1:0] hit1;
  logic [NUM_RES-1:0] hit2;
  logic [NUM_RES-1:0] hit_rd;
  logic [XLEN-1:0]    byp1;
  logic [XLEN-1:0]    byp2;
  src_res_t           src1;
  src_res_t           src2;
  logic               waw_ok;
  logic               issue;
  logic               capture;

  generate
    for (genvar gi = 0; gi < NUM_RES; gi++) begin : g_hit
      assign hit1[gi]   = res_valid[gi] && (res_rd[gi*5 +: 5] == slot_reg.rs1);
      assign hit2[gi]   = res_valid[gi] && (res_rd[gi*5 +: 5] == slot_reg.rs2);
      assign hit_rd[gi] = res_valid[gi] && (res_rd[gi*5 +: 5] == slot_reg.rd);
    end
  endgenerate

  // At most one bus targets a given register, so OR-free priority is harmless.
  always_comb begin
    byp1 = '0;
    byp2 = '0;
    for (int i = 0; i < NUM_RES; i++) begin
      if (hit1[i]) byp1 = res_data[i*XLEN +: XLEN];
      if (hit2[i]) byp2 = res_data[i*XLEN +: XLEN];
    end
  end

  assign src1 = resolve_src(slot_reg.uses_rs1, slot_reg.rs1, rs1_pend, |hit1, byp1, rf_rs1_data);
  assign src2 = resolve_src(slot_reg.uses_rs2, slot_reg.rs2, rs2_pend, |hit2, byp2, rf_rs2_data);

  // A second writer may proceed only if the older write retires this cycle.
  assign waw_ok = !(slot_reg.writes_rd && (slot_reg.rd != '0) && rd_pend && !(|hit_rd));

  assign out_valid = slot_valid_reg && src1.ready && src2.ready && waw_ok && !flush;
  assign issue     = out_valid && out_ready;
  assign in_ready  = !slot_valid_reg || issue;
  assign capture   = in_valid && in_ready && !flush;

  always_comb begin
    in_instr           = '0;
    in_instr.pc        = in_pc;
    in_instr.rs1       = in_rs1;
    in_instr.rs2       = in_rs2;
    in_instr.rd        = in_rd;
    in_instr.uses_rs1  = in_uses_rs1;
    in_instr.uses_rs2  = in_uses_rs2;
    in_instr.writes_rd = in_writes_rd;
    in_instr.payload   = in_payload;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_valid_reg <= 1'b0;
      slot_reg       <= '0;
    end else if (flush) begin
      slot_valid_reg <= 1'b0;
    end else if (capture) begin
      slot_valid_reg <= 1'b1;
      slot_reg       <= in_instr;
    end else if (issue) begin
      slot_valid_reg <= 1'b0;
    end
  end

  issue_bypass_scoreboard #(
    .NUM_CLR(NUM_RES)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue && slot_reg.writes_rd),
    .set_idx  (slot_reg.rd),
    .clr_valid(res_valid),
    .clr_idx  (res_rd),
    .rs1_idx  (slot_reg.rs1),
    .rs2_idx  (slot_reg.rs2),
    .rd_idx   (slot_reg.rd),
    .pending  (pending_vec),
    .rs1_pend (rs1_pend),
    .rs2_pend (rs2_pend),
    .rd_pend  (rd_pend)
  );

  assign rf_rs1_sel    = slot_reg.rs1;
  assign rf_rs2_sel    = slot_reg.rs2;
  assign out_pc        = slot_reg.pc;
  assign out_op1       = src1.value;
  assign out_op2       = src2.value;
  assign out_rd        = slot_reg.rd;
  assign out_writes_rd = slot_reg.writes_rd;
  assign out_payload   = slot_reg.payload;

`ifndef SYNTHESIS
  generate
    for (genvar gi = 0; gi < NUM_RES; gi++) begin : g_chk
      a_res_pending : assert property (@(posedge clk) disable iff (!rst)
        res_valid[gi] |-> pending_vec[res_rd[gi*5 +: 5]]);
      for (genvar gj = gi + 1; gj < NUM_RES; gj++) begin : g_pair
        a_res_unique : assert property (@(posedge clk) disable iff (!rst)
          !(res_valid[gi] && res_valid[gj] && (res_rd[gi*5 +: 5] == res_rd[gj*5 +: 5])));
      end
    end
  endgenerate
`endif

endmodule

// File: tb/tb_issue_bypass.sv
// Bench for issue_bypass: the bench acts as register file and execution units,
// and a behavioural model of slot, pending set and register values predicts outputs.
module tb_issue_bypass;
  import core_pkg::*;

  localparam int NR = 2;
  localparam int PW = 32;
  localparam int K_OV = 0, K_OP1 = 1, K_OP2 = 2, K_IR = 3, K_PB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              flush, in_valid, in_ready;
  logic [XLEN-1:0]   in_pc;
  logic [4:0]        in_rs1, in_rs2, in_rd;
  logic              in_uses_rs1, in_uses_rs2, in_writes_rd;
  logic [PW-1:0]     in_payload;
  logic [4:0]        rf_rs1_sel, rf_rs2_sel;
  logic [XLEN-1:0]   rf_rs1_data, rf_rs2_data;
  logic [NR-1:0]     res_valid;
  logic [NR*5-1:0]   res_rd;
  logic [NR*XLEN-1:0] res_data;
  logic              out_valid, out_ready;
  logic [XLEN-1:0]   out_pc, out_op1, out_op2;
  logic [4:0]        out_rd;
  logic              out_writes_rd;
  logic [PW-1:0]     out_payload;

  issue_bypass #(.NUM_RES(NR), .PAYLOAD_W(PW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2), .in_writes_rd(in_writes_rd),
    .in_payload(in_payload), .rf_rs1_sel(rf_rs1_sel), .rf_rs2_sel(rf_rs2_sel),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .res_valid(res_valid),
    .res_rd(res_rd), .res_data(res_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd),
    .out_writes_rd(out_writes_rd), .out_payload(out_payload)
  );

  // Model state: register values, pending destinations, and the held instruction.
  logic [XLEN-1:0] rf_m [32];
  logic [31:0]     m_pend;
  logic            m_slot_v;
  logic [XLEN-1:0] m_pc;
  logic [4:0]      m_rs1, m_rs2, m_rd;
  logic            m_u1, m_u2, m_w;
  logic [PW-1:0]   m_pl;

  assign rf_rs1_data = rf_m[rf_rs1_sel];
  assign rf_rs2_data = rf_m[rf_rs2_sel];

  // Decisions and input snapshot taken mid-cycle, applied by the model at the edge.
  logic            d_issue, d_capture, d_flush;
  logic [NR-1:0]   d_bus_v;
  logic [4:0]      d_bus_rd [NR];
  logic [XLEN-1:0] d_bus_data [NR];
  logic [XLEN-1:0] d_pc;
  logic [4:0]      d_rs1, d_rs2, d_rd;
  logic            d_u1, d_u2, d_w;
  logic [PW-1:0]   d_pl;

  // Hand-computed expectations for the current cycle, posted by the stimulus.
  int          lit_cnt;
  int          lit_kind [4];
  int          lit_idx  [4];
  logic [31:0] lit_exp  [4];
  string       lit_name [4];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_slot_v <= 1'b0;
      m_pend   <= '0;
      for (int i = 0; i < 32; i++) rf_m[i] <= (i == 6) ? 32'h10 : '0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (d_bus_v[i]) begin
          rf_m[d_bus_rd[i]]   <= d_bus_data[i];
          m_pend[d_bus_rd[i]] <= 1'b0;
        end
      end
      if (d_issue && m_w && (m_rd != 0)) m_pend[m_rd] <= 1'b1;
      if (d_flush) m_slot_v <= 1'b0;
      else if (d_capture) begin
        m_slot_v <= 1'b1;
        m_pc <= d_pc; m_rs1 <= d_rs1; m_rs2 <= d_rs2; m_rd <= d_rd;
        m_u1 <= d_u1; m_u2 <= d_u2; m_w <= d_w; m_pl <= d_pl;
      end else if (d_issue) m_slot_v <= 1'b0;
    end
  end

  function automatic logic bus_hits(input logic [4:0] r);
    for (int i = 0; i < NR; i++)
      if (res_valid[i] && (res_rd[i*5 +: 5] == r)) return 1'b1;
    return 1'b0;
  endfunction

  // Operand value of a source under the current model state and bus activity.
  function automatic logic [XLEN:0] operand(input logic used, input logic [4:0] r);
    if (!used || r == 0) return {1'b1, {XLEN{1'b0}}};
    if (!m_pend[r]) return {1'b1, rf_m[r]};
    for (int i = 0; i < NR; i++)
      if (res_valid[i] && (res_rd[i*5 +: 5] == r)) return {1'b1, res_data[i*XLEN +: XLEN]};
    return '0;
  endfunction

  always @(negedge clk) begin
    automatic logic [XLEN:0] s1, s2;
    automatic logic e_valid, e_ready, waw_block;
    if (!rst) begin
      chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
      chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
      chk("rst_pending", {32'b0, dut.pending_vec}, 64'd0);
      d_issue <= 1'b0; d_capture <= 1'b0; d_flush <= 1'b0; d_bus_v <= '0;
    end else begin
      s1 = operand(m_u1, m_rs1);
      s2 = operand(m_u2, m_rs2);
      waw_block = m_w && (m_rd != 0) && m_pend[m_rd] && !bus_hits(m_rd);
      e_valid = m_slot_v && s1[XLEN] && s2[XLEN] && !waw_block && !flush;
      e_ready = !m_slot_v || (e_valid && out_ready);
      chk("out_valid", {63'b0, out_valid}, {63'b0, e_valid});
      chk("in_ready", {63'b0, in_ready}, {63'b0, e_ready});
      chk("pending", {32'b0, dut.pending_vec}, {32'b0, m_pend});
      if (m_slot_v) begin
        chk("rf_rs1_sel", {59'b0, rf_rs1_sel}, {59'b0, m_rs1});
        chk("rf_rs2_sel", {59'b0, rf_rs2_sel}, {59'b0, m_rs2});
      end
      if (e_valid) begin
        chk("out_op1", {32'b0, out_op1}, {32'b0, s1[XLEN-1:0]});
        chk("out_op2", {32'b0, out_op2}, {32'b0, s2[XLEN-1:0]});
        chk("out_pc", {32'b0, out_pc}, {32'b0, m_pc});
        chk("out_rd", {59'b0, out_rd}, {59'b0, m_rd});
        chk("out_writes_rd", {63'b0, out_writes_rd}, {63'b0, m_w});
        chk("out_payload", {32'b0, out_payload}, {32'b0, m_pl});
      end
      d_issue   <= e_valid && out_ready;
      d_capture <= in_valid && e_ready && !flush;
      d_flush   <= flush;
      d_bus_v   <= res_valid;
      for (int i = 0; i < NR; i++) begin
        d_bus_rd[i]   <= res_rd[i*5 +: 5];
        d_bus_data[i] <= res_data[i*XLEN +: XLEN];
      end
      d_pc <= in_pc; d_rs1 <= in_rs1; d_rs2 <= in_rs2; d_rd <= in_rd;
      d_u1 <= in_uses_rs1; d_u2 <= in_uses_rs2; d_w <= in_writes_rd; d_pl <= in_payload;
    end
    for (int k = 0; k < lit_cnt; k++) begin
      case (lit_kind[k])
        K_OV:    chk(lit_name[k], {63'b0, out_valid}, {32'b0, lit_exp[k]});
        K_OP1:   chk(lit_name[k], {32'b0, out_op1}, {32'b0, lit_exp[k]});
        K_OP2:   chk(lit_name[k], {32'b0, out_op2}, {32'b0, lit_exp[k]});
        K_IR:    chk(lit_name[k], {63'b0, in_ready}, {32'b0, lit_exp[k]});
        default: chk(lit_name[k], {63'b0, dut.pending_vec[lit_idx[k]]}, {32'b0, lit_exp[k]});
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    lit_cnt = 0;
  endtask

  task automatic lit(input string name, input int kind, input int idx, input logic [31:0] exp);
    lit_name[lit_cnt] = name;
    lit_kind[lit_cnt] = kind;
    lit_idx[lit_cnt]  = idx;
    lit_exp[lit_cnt]  = exp;
    lit_cnt++;
  endtask

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0; res_valid = '0; res_rd = '0; res_data = '0;
    out_ready = 1'b1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd, input logic w);
    in_valid = 1'b1; in_pc = pc; in_rs1 = rs1; in_uses_rs1 = u1; in_rs2 = rs2;
    in_uses_rs2 = u2; in_rd = rd; in_writes_rd = w; in_payload = $urandom;
  endtask

  task automatic bus(input int b, input logic [4:0] r, input logic [31:0] data);
    res_valid[b] = 1'b1;
    res_rd[b*5 +: 5] = r;
    res_data[b*XLEN +: XLEN] = data;
  endtask

  initial begin
    lit_cnt = 0;
    rst = 1'b0;
    idle();
    offer(0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    lit("reset_out_valid", K_OV, 0, 0);
    lit("reset_in_ready", K_IR, 0, 1);
    repeat (3) tick();
    rst = 1'b1;
    tick(); offer(32'h100, 0, 1, 0, 0, 1, 1);                  // ADDI x1
    tick(); offer(32'h104, 1, 1, 0, 0, 2, 1);                  // XORI x2,x1
    lit("addi_valid", K_OV, 0, 1); lit("addi_op1", K_OP1, 0, 0);
    lit("addi_in_ready", K_IR, 0, 1);
    tick(); idle();
    lit("sb1_set", K_PB, 1, 1); lit("xori_stall", K_OV, 0, 0);
    tick(); bus(0, 1, 32'hFFFF_FFFF);
    lit("xori_bypass_valid", K_OV, 0, 1); lit("xori_bypass_op1", K_OP1, 0, 32'hFFFF_FFFF);
    tick(); idle(); offer(32'h108, 0, 1, 0, 0, 5, 1);          // LW x5
    lit("sb2_set", K_PB, 2, 1); lit("sb1_clr", K_PB, 1, 0);
    tick(); offer(32'h10C, 5, 1, 6, 1, 3, 1);                  // ADD x3,x5,x6
    lit("lw_issue", K_OV, 0, 1);
    repeat (3) begin
      tick(); idle(); lit("load_use_stall", K_OV, 0, 0);
    end
    tick(); bus(1, 5, 32'h55);
    lit("load_use_valid", K_OV, 0, 1); lit("load_use_op1", K_OP1, 0, 32'h55);
    lit("load_use_op2", K_OP2, 0, 32'h10);
    tick(); idle(); offer(32'h110, 0, 0, 0, 0, 7, 1);          // first writer of x7
    lit("sb3_set", K_PB, 3, 1);
    tick(); offer(32'h114, 0, 0, 0, 0, 7, 1);                  // second writer of x7
    lit("x7_first_issue", K_OV, 0, 1);
    tick(); idle(); lit("waw_stall", K_OV, 0, 0);
    tick(); bus(0, 7, 32'h77); lit("waw_release", K_OV, 0, 1);
    tick(); idle(); offer(32'h118, 0, 1, 0, 0, 0, 1);          // rs1=x0, rd=x0
    lit("waw_set_wins", K_PB, 7, 1);
    tick(); idle(); lit("x0_valid", K_OV, 0, 1); lit("x0_op1", K_OP1, 0, 0);
    tick(); offer(32'h11C, 7, 1, 0, 0, 8, 1);
    lit("x0_never_pending", K_PB, 0, 0);
    tick(); idle(); lit("pre_flush_stall", K_OV, 0, 0);
    tick(); flush = 1'b1; offer(32'h120, 0, 0, 0, 0, 9, 1);
    lit("flush_out_valid", K_OV, 0, 0);
    tick(); idle();
    lit("flush_in_ready", K_IR, 0, 1); lit("flush_empty", K_OV, 0, 0);
    lit("flush_keeps_x7", K_PB, 7, 1); lit("flush_keeps_x3", K_PB, 3, 1);
    tick(); offer(32'h124, 7, 1, 0, 0, 10, 1);
    tick(); idle(); lit("pre_reset_stall", K_OV, 0, 0);
    tick(); rst = 1'b0;
    lit("midrst_out_valid", K_OV, 0, 0); lit("midrst_in_ready", K_IR, 0, 1);
    lit("midrst_x7", K_PB, 7, 0); lit("midrst_x3", K_PB, 3, 0);
    tick(); rst = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      automatic logic [4:0] used_rd;
      automatic logic       used_any;
      tick();
      idle();
      out_ready = ($urandom_range(3) != 0);
      flush     = ($urandom_range(31) == 0);
      if ($urandom_range(2) != 0)
        offer($urandom, 5'($urandom_range(7)), 1'($urandom), 5'($urandom_range(7)),
              1'($urandom), 5'($urandom_range(7)), 1'($urandom));
      used_rd = '0; used_any = 1'b0;
      for (int b = 0; b < NR; b++) begin
        if ($urandom_range(2) == 0) begin
          for (int t = 0; t < 8; t++) begin
            automatic logic [4:0] r = 5'($urandom_range(7, 1));
            if (m_pend[r] && !(used_any && used_rd == r)) begin
              bus(b, r, $urandom);
              used_rd = r; used_any = 1'b1;
              break;
            end
          end
        end
      end
    end
    tick(); idle();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
